// File: rtl/rgb_weighted_unmerger.sv
// rgb_weighted_unmerger
// Recovers source-2 RGB from a weighted merge:
//   s2 = floor((m*(w1+w2) - s1*w1) / w2), clamped to [0, 2^DATA_W-1].
// All three channels share one FSM and run a bit-serial restoring divider
// in parallel, so the latency does not depend on the data.
// Handshake: a request is taken on a rising edge where data_in_valid and
// in_ready are both high; data_in_valid is ignored while in_ready is low.
// data_out_valid is a single-cycle pulse. The two are never high together.
module rgb_weighted_unmerger #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] r_m_in,
  input  logic [DATA_W-1:0] g_m_in,
  input  logic [DATA_W-1:0] b_m_in,
  input  logic [DATA_W-1:0] r1_in,
  input  logic [DATA_W-1:0] g1_in,
  input  logic [DATA_W-1:0] b1_in,
  input  logic [7:0]        weight1,
  input  logic [7:0]        weight2,
  input  logic              data_in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] g2_out,
  output logic [DATA_W-1:0] b2_out,
  output logic              data_out_valid,
  output logic [1:0]        state_dbg_o
);

  localparam int NW = 2 * DATA_W + 1;  // numerator width / divide iterations
  localparam int SW = NW + 2;          // signed width for the numerator sum
  localparam int CW = $clog2(NW + 1);  // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic signed [SW-1:0] snum_t;

  state_t state_q, state_d;

  // Captured request operands
  logic [DATA_W-1:0] m_q   [3];
  logic [DATA_W-1:0] s1_q  [3];
  logic [7:0]        w1_q, w2_q;

  // Divider state: dvd_q holds the unconsumed dividend bits in its upper
  // part and the quotient bits shifted in at the bottom.
  logic [NW-1:0]     dvd_q [3];
  logic [NW-1:0]     dvd_d [3];
  logic [7:0]        rem_q [3];
  logic [7:0]        rem_d [3];
  logic [CW-1:0]     cnt_q;

  logic [DATA_W-1:0] out_q [3];

  // Combinational helpers
  logic [DATA_W-1:0] m_in  [3];
  logic [DATA_W-1:0] s1_in [3];
  snum_t             num_s [3];
  logic [NW-1:0]     num_c [3];
  logic [DATA_W-1:0] res_c [3];
  logic [8:0]        wsum;
  logic [8:0]        shifted [3];
  logic              accept;
  logic              last_iter;

  assign m_in[0]  = r_m_in;
  assign m_in[1]  = g_m_in;
  assign m_in[2]  = b_m_in;
  assign s1_in[0] = r1_in;
  assign s1_in[1] = g1_in;
  assign s1_in[2] = b1_in;

  assign accept    = data_in_valid && (state_q == IDLE);
  assign last_iter = (state_q == DIV) && (cnt_q == CW'(NW - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_in_valid) state_d = CALC;
      CALC:    state_d = DIV;
      DIV:     if (cnt_q == CW'(NW - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only while idle, result pulse while in DONE
  always_comb begin
    in_ready       = (state_q == IDLE);
    data_out_valid = (state_q == DONE);
    state_dbg_o    = state_q;
  end

  // Signed numerator per channel; non-positive values become a zero dividend
  always_comb begin
    wsum = {1'b0, w1_q} + {1'b0, w2_q};
    for (int ch = 0; ch < 3; ch++) begin
      num_s[ch] = snum_t'(m_q[ch]) * snum_t'(wsum) - snum_t'(s1_q[ch]) * snum_t'(w1_q);
      num_c[ch] = (num_s[ch] > 0) ? num_s[ch][NW-1:0] : '0;
    end
  end

  // One restoring-division step per channel, MSB of the dividend first
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      shifted[ch] = {rem_q[ch], dvd_q[ch][NW-1]};
      if (shifted[ch] >= {1'b0, w2_q}) begin
        rem_d[ch] = 8'(shifted[ch] - {1'b0, w2_q});
        dvd_d[ch] = {dvd_q[ch][NW-2:0], 1'b1};
      end else begin
        rem_d[ch] = shifted[ch][7:0];
        dvd_d[ch] = {dvd_q[ch][NW-2:0], 1'b0};
      end
    end
  end

  // Final result: zero when the divisor is zero, otherwise saturated quotient
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      if (w2_q == 8'd0) begin
        res_c[ch] = '0;
      end else if (|dvd_d[ch][NW-1:DATA_W]) begin
        res_c[ch] = '1;
      end else begin
        res_c[ch] = dvd_d[ch][DATA_W-1:0];
      end
    end
  end

  // Datapath: capture on accept, load numerator in CALC, iterate in DIV,
  // and latch the result on the last iteration so it is stable in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        m_q[ch]   <= '0;
        s1_q[ch]  <= '0;
        dvd_q[ch] <= '0;
        rem_q[ch] <= '0;
        out_q[ch] <= '0;
      end
      w1_q  <= '0;
      w2_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        for (int ch = 0; ch < 3; ch++) begin
          m_q[ch]  <= m_in[ch];
          s1_q[ch] <= s1_in[ch];
        end
        w1_q <= weight1;
        w2_q <= weight2;
      end
      if (state_q == CALC) begin
        for (int ch = 0; ch < 3; ch++) begin
          dvd_q[ch] <= num_c[ch];
          rem_q[ch] <= '0;
        end
        cnt_q <= '0;
      end
      if (state_q == DIV) begin
        for (int ch = 0; ch < 3; ch++) begin
          dvd_q[ch] <= dvd_d[ch];
          rem_q[ch] <= rem_d[ch];
        end
        cnt_q <= cnt_q + CW'(1);
      end
      if (last_iter) begin
        for (int ch = 0; ch < 3; ch++) begin
          out_q[ch] <= res_c[ch];
        end
      end
    end
  end

  assign r2_out = out_q[0];
  assign g2_out = out_q[1];
  assign b2_out = out_q[2];

endmodule

// File: tb/tb_rgb_weighted_unmerger.sv
// Bench for rgb_weighted_unmerger: fixed vector table, held-valid burst,
// mid-operation reset and a random sweep, all checked through an expected
// queue filled at each accepted request.
module tb_rgb_weighted_unmerger;

  localparam int LAT = 19;

  logic       clk;
  logic       rst_n;
  logic [7:0] r_m_in, g_m_in, b_m_in;
  logic [7:0] r1_in, g1_in, b1_in;
  logic [7:0] weight1, weight2;
  logic       data_in_valid;
  logic       in_ready;
  logic [7:0] r2_out, g2_out, b2_out;
  logic       data_out_valid;
  logic [1:0] state_dbg_o;

  rgb_weighted_unmerger #(.DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r_m_in         (r_m_in),
    .g_m_in         (g_m_in),
    .b_m_in         (b_m_in),
    .r1_in          (r1_in),
    .g1_in          (g1_in),
    .b1_in          (b1_in),
    .weight1        (weight1),
    .weight2        (weight2),
    .data_in_valid  (data_in_valid),
    .in_ready       (in_ready),
    .r2_out         (r2_out),
    .g2_out         (g2_out),
    .b2_out         (b2_out),
    .data_out_valid (data_out_valid),
    .state_dbg_o    (state_dbg_o)
  );

  typedef struct {
    logic [23:0] m;
    logic [23:0] s1;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic [23:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_valid = 0;
  logic [23:0] cur_exp = '0;
  logic [23:0] exp_q[$];
  int          acc_q[$];
  int          acc_log[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=done");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] model(input logic [23:0] m, input logic [23:0] s1,
                                        input logic [7:0] w1, input logic [7:0] w2);
    logic [23:0] res;
    int mi, si, a, b, num, q;
    res = '0;
    a = int'(w1);
    b = int'(w2);
    for (int ch = 0; ch < 3; ch++) begin
      mi  = int'(m[23-8*ch -: 8]);
      si  = int'(s1[23-8*ch -: 8]);
      num = mi * (a + b) - si * a;
      if (b == 0 || num <= 0) q = 0;
      else q = num / b;
      if (q > 255) q = 255;
      res[23-8*ch -: 8] = 8'(q);
    end
    return res;
  endfunction

  task automatic set_in(input logic [23:0] m, input logic [23:0] s1,
                        input logic [7:0] w1, input logic [7:0] w2,
                        input logic [23:0] e, input logic v);
    {r_m_in, g_m_in, b_m_in} = m;
    {r1_in, g1_in, b1_in}    = s1;
    weight1       = w1;
    weight2       = w2;
    cur_exp       = e;
    data_in_valid = v;
  endtask

  task automatic set_rand(input logic v);
    logic [23:0] m, s1;
    logic [7:0]  w1, w2;
    m  = 24'($urandom);
    s1 = 24'($urandom);
    w1 = 8'($urandom_range(0, 255));
    w2 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    set_in(m, s1, w1, w2, model(m, s1, w1, w2), v);
  endtask

  // Present a request; while the DUT is busy, drive changing garbage with
  // valid high (must be ignored), then apply the real vector once ready.
  task automatic send(input vec_t v);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        set_in(v.m, v.s1, v.w1, v.w2, v.exp, 1'b1);
        found = 1;
        break;
      end
      set_rand(1'b1);
      @(posedge clk); #1;
    end
    if (!found) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    set_rand(1'b0);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("wait_result_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (data_out_valid) begin
        n_valid++;
        chk("ready_low_during_valid", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [23:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("result_rgb", {8'd0, r2_out, g2_out, b2_out}, {8'd0, e});
          chk("latency", 32'(cyc + 1 - a), 32'(LAT));
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  vec_t tbl[9];

  initial begin
    vec_t v;
    int   n0, nv0;

    tbl[0] = '{24'h9FA09F, 24'hFF8040, 8'd64,  8'd64,  24'h3FC0FE};
    tbl[1] = '{24'hFF00FF, 24'h00FF00, 8'd128, 8'd128, 24'hFF00FF};
    tbl[2] = '{24'hC81163, 24'h010203, 8'd50,  8'd0,   24'h000000};
    tbl[3] = '{24'h643219, 24'h123456, 8'd0,   8'd200, 24'h643219};
    tbl[4] = '{24'h030764, 24'h010232, 8'd1,   8'd2,   24'h04097D};
    tbl[5] = '{24'hFFFF00, 24'h00FF00, 8'd255, 8'd255, 24'hFFFF00};
    tbl[6] = '{24'h000102, 24'hFF0000, 8'd255, 8'd1,   24'h00FFFF};
    tbl[7] = '{24'h32007F, 24'h6400FE, 8'd1,   8'd1,   24'h000000};
    tbl[8] = '{24'h640701, 24'h000102, 8'd1,   8'd3,   24'h850900};

    rst_n = 1'b0;
    set_in(24'hA5A5A5, 24'h5A5A5A, 8'd3, 8'd7, 24'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(data_out_valid), 32'd0);
    chk("reset_outputs", {8'd0, r2_out, g2_out, b2_out}, 32'd0);
    chk("reset_state", 32'(state_dbg_o), 32'd0);
    chk("reset_no_accept", 32'(acc_log.size()), 32'd0);
    data_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed table
    foreach (tbl[i]) begin
      send(tbl[i]);
      wait_idle();
    end

    // Valid held high for 60 cycles with changing data
    n0 = acc_log.size();
    for (int i = 0; i < 60; i++) begin
      set_rand(1'b1);
      @(posedge clk); #1;
    end
    set_rand(1'b0);
    wait_idle();
    chk("burst_accept_count", 32'(acc_log.size() - n0), 32'd3);
    if (acc_log.size() - n0 == 3) begin
      chk("burst_spacing_1", 32'(acc_log[n0+1] - acc_log[n0]), 32'd20);
      chk("burst_spacing_2", 32'(acc_log[n0+2] - acc_log[n0+1]), 32'd20);
    end

    // Reset during the divide phase
    v = tbl[4];
    send(v);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_reset_in_div", 32'(state_dbg_o), 32'd2);
    nv0 = n_valid;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("async_reset_outputs", {8'd0, r2_out, g2_out, b2_out}, 32'd0);
    chk("async_reset_valid", 32'(data_out_valid), 32'd0);
    chk("async_reset_ready", 32'(in_ready), 32'd1);
    chk("async_reset_state", 32'(state_dbg_o), 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("no_valid_after_abort", 32'(n_valid - nv0), 32'd0);
    send(tbl[0]);
    wait_idle();
    chk("post_reset_request_done", 32'(n_valid - nv0), 32'd1);

    // Random sweep against the reference model
    for (int i = 0; i < 300; i++) begin
      v.m  = 24'($urandom);
      v.s1 = 24'($urandom);
      v.w1 = 8'($urandom_range(0, 255));
      v.w2 = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      v.exp = model(v.m, v.s1, v.w1, v.w2);
      send(v);
    end
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
